// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core datapath: result-select and load
// type encodings, plus the architectural widths used as parameter defaults.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Writeback result source, as decoded in ID and carried down the pipe.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  // Load funct3 encodings; 011, 110 and 111 are not legal loads in RV32I.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_t;

endpackage

// File: rtl/load_extend.sv
// Load byte/half lane extraction with sign/zero extension and alignment
// checking. Purely combinational so the store/AMO unit can share it.
module load_extend
  import core_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Replicate the top bit of a byte into the full word.
  function automatic logic signed [XLEN-1:0] sext8(input logic [7:0] b);
    logic signed [7:0] sb;
    sb = $signed(b);
    return XLEN'(sb);
  endfunction

  // Replicate the top bit of a halfword into the full word.
  function automatic logic signed [XLEN-1:0] sext16(input logic [15:0] h);
    logic signed [15:0] sh;
    sh = $signed(h);
    return XLEN'(sh);
  endfunction

  // Lane selects: byte lane picked by the full offset, half lane by offset[1].
  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = word[{offset[1], 4'b0000} +: 16];
  end

  // Extend the selected lane by load type and flag alignment / encoding faults.
  always_comb begin
    value      = '0;
    misaligned = 1'b0;
    case (funct3)
      LB: begin
        value = sext8(byte_lane);
      end
      LBU: begin
        value = {{(XLEN-8){1'b0}}, byte_lane};
      end
      LH: begin
        value      = sext16(half_lane);
        misaligned = offset[0];
      end
      LHU: begin
        value      = {{(XLEN-16){1'b0}}, half_lane};
        misaligned = offset[0];
      end
      LW: begin
        value      = word;
        misaligned = (offset != 2'b00);
      end
      default: begin
        // Reserved load encodings are reported through the same flag so the
        // stage suppresses the write.
        value      = '0;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_result_stage.sv
// MEM/WB pipeline register plus writeback result selection. Drives the
// register-file write port and the WB forwarding path from registered state
// only, so nothing from the MEM stage reaches the outputs in the same cycle.
module wb_result_stage
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [1:0]            in_result_src,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_read_data,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic [DATA_WIDTH-1:0] in_imm_ext,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_reg_write,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_result,
  output logic [ADDR_WIDTH-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  wb_misaligned
);

  // The load extractor and lane arithmetic are written for RV32 only.
  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("wb_result_stage: only DATA_WIDTH = 32 is supported");
    end
  endgenerate

  logic                  vld_p0;
  result_src_t           src_p0;
  logic [DATA_WIDTH-1:0] alu_p0;
  logic [DATA_WIDTH-1:0] read_p0;
  logic [DATA_WIDTH-1:0] pc4_p0;
  logic [DATA_WIDTH-1:0] imm_p0;
  logic [2:0]            f3_p0;
  logic [ADDR_WIDTH-1:0] rd_p0;
  logic                  rw_p0;

  logic [DATA_WIDTH-1:0] ext_val;
  logic                  ext_mis;
  logic                  mis;
  logic [DATA_WIDTH-1:0] sel_val;

  // ---- MEM -> WB boundary: reset, then flush, then stall, else capture ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p0  <= 1'b0;
      src_p0  <= RES_ALU;
      alu_p0  <= '0;
      read_p0 <= '0;
      pc4_p0  <= '0;
      imm_p0  <= '0;
      f3_p0   <= '0;
      rd_p0   <= '0;
      rw_p0   <= 1'b0;
    end else if (!stall) begin
      vld_p0  <= in_valid;
      src_p0  <= result_src_t'(in_result_src);
      alu_p0  <= in_alu_result;
      read_p0 <= in_read_data;
      pc4_p0  <= in_pc_plus4;
      imm_p0  <= in_imm_ext;
      f3_p0   <= in_funct3;
      rd_p0   <= in_rd;
      rw_p0   <= in_reg_write;
    end
  end

  load_extend u_load_extend (
    .funct3     (f3_p0),
    .offset     (alu_p0[1:0]),
    .word       (read_p0),
    .value      (ext_val),
    .misaligned (ext_mis)
  );

  // Select the writeback value and qualify the write enable; bubbles and
  // faulting loads present zero so the forwarding mux never sees stale data.
  always_comb begin
    mis = vld_p0 && (src_p0 == RES_MEM) && ext_mis;
    case (src_p0)
      RES_ALU: sel_val = alu_p0;
      RES_MEM: sel_val = ext_val;
      RES_PC4: sel_val = pc4_p0;
      RES_IMM: sel_val = imm_p0;
      default: sel_val = alu_p0;
    endcase
    wb_valid      = vld_p0;
    wb_rd         = rd_p0;
    wb_misaligned = mis;
    wb_result     = (vld_p0 && !mis) ? sel_val : '0;
    wb_reg_write  = vld_p0 && rw_p0 && (rd_p0 != '0) && !mis;
  end

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed test-plan steps followed by randomized
// traffic, all checked against a field-level model of the stage.
module tb_wb_result_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid;
  logic [1:0]  in_result_src;
  logic [31:0] in_alu_result, in_read_data, in_pc_plus4, in_imm_ext;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_misaligned;

  int total = 0;
  int bad   = 0;

  // model of what the stage currently holds
  bit          m_valid;
  int unsigned m_src, m_f3, m_rd;
  bit          m_rw;
  logic [31:0] m_alu, m_rdat, m_pc4, m_imm;

  // expected outputs
  logic        e_valid, e_we, e_mis;
  logic [31:0] e_res;
  logic [4:0]  e_rd;

  wb_result_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_result_src(in_result_src),
    .in_alu_result(in_alu_result), .in_read_data(in_read_data),
    .in_pc_plus4(in_pc_plus4), .in_imm_ext(in_imm_ext),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Interpret value as a 'bits'-wide two's complement number, return as 32 bits.
  function automatic logic [31:0] sx(input longint v, input int bits);
    longint r;
    r = (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    return r[31:0];
  endfunction

  task automatic compute_expect();
    int unsigned off;
    longint      lane;
    logic [31:0] ld, pick;
    bit          fault;
    off   = m_alu % 4;
    fault = 0;
    ld    = 0;
    case (m_f3)
      0: begin lane = (longint'(m_rdat) >> (8 * off)) % 256; ld = sx(lane, 8); end
      4: begin lane = (longint'(m_rdat) >> (8 * off)) % 256; ld = lane[31:0]; end
      1: begin lane = (longint'(m_rdat) >> (16 * (off / 2))) % 65536; ld = sx(lane, 16); fault = (off % 2) != 0; end
      5: begin lane = (longint'(m_rdat) >> (16 * (off / 2))) % 65536; ld = lane[31:0]; fault = (off % 2) != 0; end
      2: begin ld = m_rdat; fault = off != 0; end
      default: fault = 1;
    endcase
    case (m_src)
      0: pick = m_alu;
      1: pick = ld;
      2: pick = m_pc4;
      default: pick = m_imm;
    endcase
    e_mis   = m_valid && (m_src == 1) && fault;
    e_valid = m_valid;
    e_rd    = m_rd[4:0];
    e_res   = (m_valid && !e_mis) ? pick : 32'h0;
    e_we    = m_valid && m_rw && (m_rd != 0) && !e_mis;
  endtask

  task automatic check_all(input string where);
    compute_expect();
    chk({where, ".valid"}, {31'b0, wb_valid}, {31'b0, e_valid});
    chk({where, ".result"}, wb_result, e_res);
    chk({where, ".rd"}, {27'b0, wb_rd}, {27'b0, e_rd});
    chk({where, ".we"}, {31'b0, wb_reg_write}, {31'b0, e_we});
    chk({where, ".mis"}, {31'b0, wb_misaligned}, {31'b0, e_mis});
  endtask

  task automatic model_clear();
    m_valid = 0; m_src = 0; m_f3 = 0; m_rd = 0; m_rw = 0;
    m_alu = 0; m_rdat = 0; m_pc4 = 0; m_imm = 0;
  endtask

  // Apply one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    if (rst || flush) model_clear();
    else if (!stall) begin
      m_valid = in_valid;   m_src = in_result_src; m_f3 = in_funct3;
      m_rd    = in_rd;      m_rw  = in_reg_write;
      m_alu   = in_alu_result; m_rdat = in_read_data;
      m_pc4   = in_pc_plus4;   m_imm  = in_imm_ext;
    end
  endtask

  // New inputs must not disturb outputs before the edge; then check after it.
  task automatic cycle(input string where);
    #1;
    check_all({where, ".pre"});
    @(posedge clk);
    #1;
    model_edge();
    check_all(where);
    @(negedge clk);
  endtask

  task automatic set_instr(input bit v, input logic [1:0] src, input logic [31:0] alu,
                           input logic [31:0] rdat, input logic [31:0] pc4,
                           input logic [31:0] imm, input logic [2:0] f3,
                           input logic [4:0] rd, input bit rw);
    in_valid = v; in_result_src = src; in_alu_result = alu; in_read_data = rdat;
    in_pc_plus4 = pc4; in_imm_ext = imm; in_funct3 = f3; in_rd = rd; in_reg_write = rw;
  endtask

  task automatic set_random();
    set_instr($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 1));
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    set_random();
    @(posedge clk);
    #1;
    model_clear();
    @(negedge clk);

    // outputs stay zero through reset regardless of inputs
    for (int i = 0; i < 3; i++) begin
      set_random();
      stall = i[0];
      cycle("reset");
    end
    stall = 0;
    rst = 0;

    set_instr(1, 2'b00, 32'h0000_1234, 32'hDEAD_BEEF, 32'h10, 32'h20, 3'b010, 5'd5, 1);
    cycle("alu");
    chk("alu.const", wb_result, 32'h0000_1234);
    chk("alu.we", {31'b0, wb_reg_write}, 32'd1);

    set_instr(1, 2'b01, 32'h0000_1001, 32'h80FF_7F01, 0, 0, 3'b000, 5'd6, 1);
    cycle("lb1");
    chk("lb1.const", wb_result, 32'h0000_007F);
    set_instr(1, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 0, 0, 3'b000, 5'd6, 1);
    cycle("lb3");
    chk("lb3.const", wb_result, 32'hFFFF_FF80);
    set_instr(1, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 0, 0, 3'b100, 5'd6, 1);
    cycle("lbu3");
    chk("lbu3.const", wb_result, 32'h0000_0080);
    set_instr(1, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 0, 0, 3'b001, 5'd6, 1);
    cycle("lh2");
    chk("lh2.const", wb_result, 32'hFFFF_80FF);

    set_instr(1, 2'b01, 32'h0000_1001, 32'h80FF_7F01, 0, 0, 3'b001, 5'd7, 1);
    cycle("lh1mis");
    chk("lh1mis.flag", {31'b0, wb_misaligned}, 32'd1);
    set_instr(1, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 0, 0, 3'b010, 5'd7, 1);
    cycle("lw2mis");
    chk("lw2mis.flag", {31'b0, wb_misaligned}, 32'd1);
    chk("lw2mis.res", wb_result, 32'h0);
    set_instr(1, 2'b01, 32'h0000_1000, 32'h1234_5678, 0, 0, 3'b110, 5'd7, 1);
    cycle("badf3");

    set_instr(1, 2'b10, 32'h0000_0040, 0, 32'h0000_0104, 0, 3'b000, 5'd1, 1);
    cycle("jal");
    chk("jal.const", wb_result, 32'h0000_0104);
    set_instr(1, 2'b11, 32'h0, 0, 0, 32'hABCD_E000, 3'b000, 5'd0, 1);
    cycle("lui_x0");
    chk("lui_x0.we", {31'b0, wb_reg_write}, 32'd0);

    // stall for three cycles with changing inputs
    set_instr(1, 2'b00, 32'h0000_5A5A, 0, 0, 0, 3'b000, 5'd9, 1);
    cycle("pre_stall");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_random();
      cycle("stall");
      chk("stall.frozen", wb_result, 32'h0000_5A5A);
    end
    flush = 1;
    cycle("flush_stall");
    chk("flush_stall.valid", {31'b0, wb_valid}, 32'd0);
    flush = 0; stall = 0;

    // back-to-back instructions, one per cycle
    for (int i = 0; i < 4; i++) begin
      set_instr(1, 2'b00, 32'h100 + i, 0, 0, 0, 3'b000, 5'(10 + i), 1);
      cycle("b2b");
      chk("b2b.order", wb_result, 32'h100 + i);
    end

    // randomized traffic with occasional reset, flush and stall
    for (int i = 0; i < 300; i++) begin
      set_random();
      rst   = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 10);
      stall = ($urandom_range(0, 99) < 25);
      cycle("rand");
    end
    rst = 0; flush = 0; stall = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
